// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queued JK command driver with a reference model and a q self-check
module jk_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int REP_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_j,
  input  logic             cmd_k,
  input  logic [REP_W-1:0] cmd_rep,
  input  logic             flush,
  input  logic             check_en,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             exp_q,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t state_q, state_d;
  logic [REP_W+1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic j_q, j_d, k_q, k_d, exp_q_q, exp_q_d, mismatch_q, mismatch_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic full, empty, push, pop;
  assign full      = cnt_q == (AW+1)'(DEPTH);
  assign empty     = cnt_q == '0;
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;
  assign pop       = !flush && !empty && (state_q == IDLE || rep_cnt_q == '0);
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    k_d       = k_q;
    rep_cnt_d = rep_cnt_q;
    if (flush) begin
      state_d = IDLE;
      j_d     = 1'b0;
      k_d     = 1'b0;
    end else if (pop) begin
      state_d                  = DRIVE;
      {j_d, k_d, rep_cnt_d}    = mem_q[rd_ptr_q];
    end else if (state_q == DRIVE && rep_cnt_q != '0) begin
      rep_cnt_d = rep_cnt_q - 1'b1;
    end else begin
      state_d = IDLE;
      j_d     = 1'b0;
      k_d     = 1'b0;
    end
  end
  assign wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
  assign rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop);
  assign cnt_d      = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  // Model follows the driven flop at the same edge, so it uses the registered j/k
  assign exp_q_d    = (j_q & ~exp_q_q) | (~k_q & exp_q_q);
  assign mismatch_d = check_en && (q_fb != exp_q_q);
  assign err_cnt_d  = (mismatch_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rep_cnt_q  <= '0;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      exp_q_q    <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      exp_q_q    <= exp_q_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_j, cmd_k, cmd_rep};
  end
  assign j        = j_q;
  assign k        = k_q;
  assign busy     = state_q == DRIVE;
  assign exp_q    = exp_q_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
endmodule
